program_loader: RTL and testbench
=================================

# program_loader

Streams a program image into the 10-bit instruction memory over a valid/ready word interface while holding the CPU core in reset, then releases the core. It is the write side of the instruction-fetch path: the fetch unit only reads instruction memory, and this block is the writer that fills it at boot or on reload. A trailing XOR checksum word validates the image before the core is allowed to run.

## Interface
Parameters:
- `DATA_W`, default 10: instruction word width.
- `ADDR_W`, default 10: instruction memory address width.
- `DEPTH`, default 1024: maximum number of program words. Must be ≤ 2^ADDR_W.

Ports:
- `clk`, in, 1: single system clock. All logic is rising-edge.
- `reset`, in, 1: asynchronous, active-low reset (low = reset).
- `start`, in, 1: one-cycle pulse that begins a load.
- `s_valid`, in, 1: a stream word is present.
- `s_data`, in, DATA_W: stream word.
- `s_last`, in, 1: qualifies the checksum word, which is the final word of the image.
- `s_ready`, out, 1: the loader accepts a word this cycle.
- `imem_we`, out, 1: instruction memory write strobe.
- `imem_addr`, out, ADDR_W: write address.
- `imem_wdata`, out, DATA_W: write data.
- `cpu_run`, out, 1: 1 releases the core; 0 holds it in reset.
- `busy`, out, 1: a load is in progress.
- `done`, out, 1: the last load passed its checksum.
- `error`, out, 1: the last load failed (checksum mismatch or overflow).
- `word_count`, out, ADDR_W+1: number of program words written by the current or last load.

## Operation
- FSM states: IDLE, LOAD, CHECK, DONE, ERROR. Reset enters IDLE.
- IDLE, DONE, ERROR:
  - `start` → LOAD.
  - On entry to LOAD, clear `word_count`, the write address, the checksum accumulator, `done` and `error`.
  - Drive `cpu_run` = 0 from the first LOAD cycle.
- LOAD:
  - `s_ready` = 1.
  - On handshake (`s_valid` & `s_ready`) with `s_last` = 0:
    - write `s_data` to address `word_count`;
    - XOR `s_data` into the accumulator;
    - increment `word_count`.
  - On handshake with `s_last` = 1: latch `s_data` as the expected checksum → CHECK. This word is not written.
  - Overflow: a non-last handshake when `word_count` == DEPTH is not written → ERROR.
- CHECK (1 cycle):
  - accumulator == expected → DONE;
  - otherwise → ERROR.
- DONE: `done` = 1, `cpu_run` = 1, `busy` = 0.
- ERROR: `error` = 1, `cpu_run` = 0, `busy` = 0.
- `busy` = 1 in LOAD and CHECK.
- `start` during LOAD or CHECK is ignored.
- An empty image (first handshake has `s_last`) gives checksum 0. Expected 0 → DONE with `word_count` 0.
- Arithmetic:
  - checksum is a bitwise XOR over DATA_W bits, initial value 0;
  - `word_count` is unsigned, ADDR_W+1 bits, so that DEPTH is representable;
  - `imem_addr` = `word_count`[ADDR_W-1:0] at write time. There is no wrap, because overflow is detected first.

## Timing
- All outputs are registered.
- Reset values: `s_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `cpu_run` 0, `busy` 0, `done` 0, `error` 0, `word_count` 0.
- `start` is sampled at cycle N. State is LOAD and `s_ready` = 1 at N+1.
- A data handshake at cycle N gives `imem_we` = 1 at N+1, with `imem_addr`/`imem_wdata` valid at N+1. `word_count` updates at N+1.
- Throughput: one word per cycle. `s_ready` stays 1 throughout LOAD and drops in the cycle after the `s_last` handshake.
- An `s_last` handshake at N puts the FSM in CHECK at N+1. `done`/`error` and `cpu_run` update at N+2.
- Reset asserted mid-load aborts immediately:
  - all outputs go to their reset values asynchronously, including `imem_we` = 0;
  - `cpu_run` = 0;
  - memory contents are undefined.
- A re-`start` from DONE drops `cpu_run` at the next edge, before any write occurs.

## Structure
- A shared package holds:
  - the FSM state enum (`LDR_IDLE`, `LDR_LOAD`, `LDR_CHECK`, `LDR_DONE`, `LDR_ERROR`);
  - the `DATA_W`/`ADDR_W` defaults (10/10) shared with the CPU, fetch unit and instruction memory.
- One sub-module, `xor_checksum`, holds the accumulator with clear and enable inputs and a DATA_W-bit output.
- The FSM, counter and output registers live in `program_loader`.

## Test plan
- Reset, then `start`, then stream 0x3FF, 0x001, 0x155 followed by `s_last` word 0x2AB → writes at addresses 0, 1, 2 with those values; `word_count` = 3; `done` = 1, `cpu_run` = 1 two cycles after `s_last`.
- Same image but checksum 0x000 → no `done`; `error` = 1; `cpu_run` stays 0; the three words are still written.
- `s_valid` toggling every other cycle with the same image → identical writes, each `imem_we` one cycle after its handshake, no duplicates.
- DEPTH = 4, five data words → addresses 0–3 written; the fifth word is not written; `error` = 1; `word_count` = 4.
- Reset pulled low after two words of a load → all outputs read 0 immediately. The next `start` writes from address 0 again.
- Empty image (first word has `s_last`, data 0x000) → DONE, `word_count` = 0, no `imem_we`. A following `start` drops `cpu_run` to 0 the next cycle.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the
// instruction-path word/address widths used by the CPU, fetch unit and imem.
package program_loader_pkg;

  localparam int unsigned LDR_DATA_W = 10;
  localparam int unsigned LDR_ADDR_W = 10;

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_LOAD  = 3'd1,
    LDR_CHECK = 3'd2,
    LDR_DONE  = 3'd3,
    LDR_ERROR = 3'd4
  } ldr_state_e;

endpackage

// File: rtl/xor_checksum.sv
// Running XOR accumulator over the program image; clear has priority over enable.
module xor_checksum
  import program_loader_pkg::*;
#(
  parameter int unsigned DATA_W = LDR_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] sum_o
);

  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q ^ data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/program_loader.sv
// Streams a checksummed program image into instruction memory while holding
// the core in reset; releases the core only after a good checksum.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned DATA_W = LDR_DATA_W,
  parameter int unsigned ADDR_W = LDR_ADDR_W,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  ldr_state_e        state_q, state_d;
  logic              s_ready_q, s_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
  logic              cpu_run_q, cpu_run_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic [DATA_W-1:0] expected_q, expected_d;

  logic              csum_clr, csum_en;
  logic [DATA_W-1:0] csum;

  xor_checksum #(
    .DATA_W (DATA_W)
  ) u_xor_checksum (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (csum_clr),
    .en_i   (csum_en),
    .data_i (s_data),
    .sum_o  (csum)
  );

  // Next state, datapath updates and registered output values.
  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    word_count_d = word_count_q;
    expected_d   = expected_q;
    csum_clr     = 1'b0;
    csum_en      = 1'b0;

    case (state_q)
      LDR_IDLE, LDR_DONE, LDR_ERROR: begin
        if (start) begin
          state_d      = LDR_LOAD;
          word_count_d = '0;
          imem_addr_d  = '0;
          csum_clr     = 1'b1;
        end
      end
      LDR_LOAD: begin
        if (s_valid && s_ready_q) begin
          if (s_last) begin
            expected_d = s_data;
            state_d    = LDR_CHECK;
          end else if (word_count_q == CNT_W'(DEPTH)) begin
            // Image larger than memory: drop the word rather than wrap.
            state_d = LDR_ERROR;
          end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_count_q[ADDR_W-1:0];
            imem_wdata_d = s_data;
            word_count_d = word_count_q + CNT_W'(1);
            csum_en      = 1'b1;
          end
        end
      end
      LDR_CHECK: begin
        state_d = (csum == expected_q) ? LDR_DONE : LDR_ERROR;
      end
      default: begin
        state_d = LDR_IDLE;
      end
    endcase

    s_ready_d = (state_d == LDR_LOAD);
    busy_d    = (state_d == LDR_LOAD) || (state_d == LDR_CHECK);
    done_d    = (state_d == LDR_DONE);
    error_d   = (state_d == LDR_ERROR);
    cpu_run_d = (state_d == LDR_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LDR_IDLE;
      s_ready_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_run_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= '0;
      expected_q   <= '0;
    end else begin
      state_q      <= state_d;
      s_ready_q    <= s_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_run_q    <= cpu_run_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      word_count_q <= word_count_d;
      expected_q   <= expected_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_run    = cpu_run_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a full-depth and a 4-deep instance share one stream.
module tb_program_loader;

  localparam int unsigned DW          = 10;
  localparam int unsigned AW          = 10;
  localparam int unsigned CW          = AW + 1;
  localparam int          SMALL_DEPTH = 4;
  localparam int          BIG_DEPTH   = 1024;

  logic          clk = 1'b0;
  logic          reset, start, s_valid, s_last;
  logic [DW-1:0] s_data;

  logic          rdy_b, we_b, run_b, busy_b, done_b, err_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wd_b;
  logic [CW-1:0] cnt_b;
  logic          rdy_s, we_s, run_s, busy_s, done_s, err_s;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] wd_s;
  logic [CW-1:0] cnt_s;

  always #5 clk = ~clk;

  program_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(BIG_DEPTH)) u_big (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(rdy_b), .imem_we(we_b), .imem_addr(addr_b),
    .imem_wdata(wd_b), .cpu_run(run_b), .busy(busy_b), .done(done_b),
    .error(err_b), .word_count(cnt_b)
  );

  program_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(SMALL_DEPTH)) u_small (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(rdy_s), .imem_we(we_s), .imem_addr(addr_s),
    .imem_wdata(wd_s), .cpu_run(run_s), .busy(busy_s), .done(done_s),
    .error(err_s), .word_count(cnt_s)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int            n;
    logic [DW-1:0] w [8];
    logic [DW-1:0] cs;
    int            gap;
    bit            exp_done;
    int            exp_cnt;
  } vec_t;

  wr_t wq_b[$];
  wr_t wq_s[$];
  int  hs_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Collect writes; every full-depth write must land exactly one cycle after its handshake.
  always @(negedge clk) begin
    int h;
    cyc++;
    if (we_b) begin
      wq_b.push_back('{addr_b, wd_b});
      if (hs_q.size() != 0) h = hs_q.pop_front();
      else h = -10;
      chk("we_latency", 32'(cyc - h), 32'd1);
    end
    if (we_s) wq_s.push_back('{addr_s, wd_s});
    if (s_valid && rdy_b && !s_last) hs_q.push_back(cyc);
  end

  // Reference: image fits -> all words written, pass iff XOR matches; too big -> first depth words, fail.
  function automatic void model(input logic [DW-1:0] w[$], input logic [DW-1:0] cs,
                                input int depth, output int nwr, output bit dn);
    logic [DW-1:0] acc;
    acc = '0;
    if (w.size() > depth) begin
      nwr = depth;
      dn  = 1'b0;
      return;
    end
    foreach (w[i]) acc ^= w[i];
    nwr = w.size();
    dn  = (acc == cs);
  endfunction

  function automatic vec_t mkv(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [DW-1:0] c, input logic [DW-1:0] d,
                               input logic [DW-1:0] e, input logic [DW-1:0] cs,
                               input int gap, input bit ed, input int ec);
    vec_t v;
    v.n = n;
    v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d; v.w[4] = e;
    v.w[5] = '0; v.w[6] = '0; v.w[7] = '0;
    v.cs = cs; v.gap = gap; v.exp_done = ed; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic idle(input int gap);
    int n;
    n = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
    s_valid = 1'b0;
    s_data  = DW'($urandom);
    repeat (n) step();
  endtask

  task automatic drive_word(input logic [DW-1:0] d, input logic l);
    int t;
    t       = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!rdy_b && t < 20) begin
      step();
      t++;
    end
    chk("handshake_wait", 32'(t < 20), 32'd1);
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Full load; returns one cycle after CHECK, when done/error/cpu_run are final.
  task automatic run_image(input logic [DW-1:0] w[$], input logic [DW-1:0] cs, input int gap);
    wq_b.delete();
    wq_s.delete();
    hs_q.delete();
    pulse_start();
    chk("load_ready", 32'(rdy_b), 32'd1);
    chk("load_cnt_clear", 32'(cnt_b), 32'd0);
    foreach (w[i]) begin
      idle(gap);
      drive_word(w[i], 1'b0);
    end
    idle(gap);
    drive_word(cs, 1'b1);
    chk("check_busy", 32'(busy_b), 32'd1);
    chk("check_ready_low", 32'(rdy_b), 32'd0);
    chk("check_done_late", 32'(done_b), 32'd0);
    step();
  endtask

  task automatic check_result(input string tag, input logic [DW-1:0] w[$], input logic [DW-1:0] cs,
                              input bit ed, input int ec);
    int nwr_s;
    bit dn_s;
    model(w, cs, SMALL_DEPTH, nwr_s, dn_s);
    chk({tag, "_done"}, 32'(done_b), 32'(ed));
    chk({tag, "_error"}, 32'(err_b), 32'(!ed));
    chk({tag, "_cpu_run"}, 32'(run_b), 32'(ed));
    chk({tag, "_busy"}, 32'(busy_b), 32'd0);
    chk({tag, "_count"}, 32'(cnt_b), 32'(ec));
    chk({tag, "_nwrites"}, 32'(wq_b.size()), 32'(ec));
    for (int i = 0; i < wq_b.size() && i < w.size(); i++) begin
      chk({tag, "_addr"}, 32'(wq_b[i].addr), 32'(i));
      chk({tag, "_data"}, 32'(wq_b[i].data), 32'(w[i]));
    end
    chk({tag, "_sm_done"}, 32'(done_s), 32'(dn_s));
    chk({tag, "_sm_error"}, 32'(err_s), 32'(!dn_s));
    chk({tag, "_sm_cpu_run"}, 32'(run_s), 32'(dn_s));
    chk({tag, "_sm_count"}, 32'(cnt_s), 32'(nwr_s));
    chk({tag, "_sm_nwrites"}, 32'(wq_s.size()), 32'(nwr_s));
    for (int i = 0; i < wq_s.size() && i < w.size(); i++) begin
      chk({tag, "_sm_addr"}, 32'(wq_s[i].addr), 32'(i));
      chk({tag, "_sm_data"}, 32'(wq_s[i].data), 32'(w[i]));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 32'(rdy_b | rdy_s), 32'd0);
    chk({tag, "_we"}, 32'(we_b | we_s), 32'd0);
    chk({tag, "_addr"}, 32'(addr_b | addr_s), 32'd0);
    chk({tag, "_wdata"}, 32'(wd_b | wd_s), 32'd0);
    chk({tag, "_cpu_run"}, 32'(run_b | run_s), 32'd0);
    chk({tag, "_busy"}, 32'(busy_b | busy_s), 32'd0);
    chk({tag, "_done"}, 32'(done_b | done_s), 32'd0);
    chk({tag, "_error"}, 32'(err_b | err_s), 32'd0);
    chk({tag, "_count"}, 32'(cnt_b | cnt_s), 32'd0);
  endtask

  initial begin
    vec_t          tbl [6];
    logic [DW-1:0] w[$];
    logic [DW-1:0] cs;
    int            nwr;
    bit            dn;

    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    #2 reset = 1'b0;
    #1 check_zero("reset");
    #19 reset = 1'b1;
    step();

    tbl[0] = mkv(3, 10'h3FF, 10'h001, 10'h155, 10'h000, 10'h000, 10'h2AB, 0, 1'b1, 3);
    tbl[1] = mkv(3, 10'h3FF, 10'h001, 10'h155, 10'h000, 10'h000, 10'h000, 0, 1'b0, 3);
    tbl[2] = mkv(3, 10'h3FF, 10'h001, 10'h155, 10'h000, 10'h000, 10'h2AB, 1, 1'b1, 3);
    tbl[3] = mkv(5, 10'h3FF, 10'h001, 10'h155, 10'h0AA, 10'h2B7, 10'h0B6, 0, 1'b1, 5);
    tbl[4] = mkv(0, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 0, 1'b1, 0);
    tbl[5] = mkv(0, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h155, 0, 1'b0, 0);

    for (int t = 0; t < 6; t++) begin
      w.delete();
      for (int i = 0; i < tbl[t].n; i++) w.push_back(tbl[t].w[i]);
      run_image(w, tbl[t].cs, tbl[t].gap);
      check_result($sformatf("vec%0d", t), w, tbl[t].cs, tbl[t].exp_done, tbl[t].exp_cnt);
    end

    // Re-start from DONE releases nothing: the core goes back into reset at once.
    w.delete();
    run_image(w, 10'h000, 0);
    chk("empty_done", 32'(done_b), 32'd1);
    pulse_start();
    chk("restart_cpu_run", 32'(run_b), 32'd0);
    chk("restart_busy", 32'(busy_b), 32'd1);
    chk("restart_done_clr", 32'(done_b), 32'd0);
    chk("restart_we", 32'(we_b), 32'd0);
    drive_word(10'h000, 1'b1);
    step();
    chk("restart_redone", 32'(done_b), 32'd1);

    // A start pulse mid-load must not restart the count.
    wq_b.delete(); wq_s.delete(); hs_q.delete();
    pulse_start();
    drive_word(10'h123, 1'b0);
    drive_word(10'h045, 1'b0);
    pulse_start();
    drive_word(10'h300, 1'b0);
    drive_word(10'h123 ^ 10'h045 ^ 10'h300, 1'b1);
    step();
    w.delete();
    w.push_back(10'h123); w.push_back(10'h045); w.push_back(10'h300);
    check_result("start_in_load", w, 10'h123 ^ 10'h045 ^ 10'h300, 1'b1, 3);

    // Reset mid-load clears everything asynchronously; next load writes from address 0.
    pulse_start();
    drive_word(10'h0F0, 1'b0);
    drive_word(10'h00F, 1'b0);
    #2 reset = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    step();
    w.delete();
    w.push_back(10'h2C3);
    run_image(w, 10'h2C3, 0);
    check_result("after_reset", w, 10'h2C3, 1'b1, 1);

    // Randomized images against the reference model.
    for (int r = 0; r < 30; r++) begin
      w.delete();
      for (int i = 0; i < int'($urandom_range(0, 7)); i++) w.push_back(DW'($urandom));
      cs = '0;
      foreach (w[i]) cs ^= w[i];
      if ($urandom_range(0, 2) == 0) cs = cs ^ DW'($urandom_range(1, 1023));
      run_image(w, cs, 2);
      model(w, cs, BIG_DEPTH, nwr, dn);
      check_result($sformatf("rand%0d", r), w, cs, dn, nwr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
